// File: rtl/pipe_mux.sv
// Pipelined N-to-1 data select with valid tag, whole-pipe stall and out-of-range select flagging.
// Capture stage plus LATENCY follow-on stages; stall freezes every stage, err_sticky sets on acceptance.
module pipe_mux #(
  parameter int N_INPUTS = 2,
  parameter int DWIDTH   = 8,
  parameter int LATENCY  = 1,
  parameter bit HOLD_OUT = 1'b1,
  localparam int SEL_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in [N_INPUTS],
  input  logic [SEL_W-1:0]  sel,
  input  logic              stall,
  input  logic              err_clr,
  output logic [DWIDTH-1:0] out,
  output logic              out_valid,
  output logic [SEL_W-1:0]  out_sel,
  output logic              sel_err,
  output logic              err_sticky
);

  // Stage 0 is the acceptance register; the beat then crosses LATENCY more stages.
  localparam int NSTG = LATENCY + 1;

  typedef struct packed {
    logic              vld;
    logic              err;
    logic [SEL_W-1:0]  sel;
    logic [DWIDTH-1:0] dat;
  } stage_t;

  stage_t            stg_q [NSTG];
  stage_t            stg_d [NSTG];
  stage_t            beat_in;
  logic [DWIDTH-1:0] mux_dat;
  logic              sel_oor;
  logic              err_sticky_q;
  logic              err_sticky_d;

  // A bubble keeps the stage's previous data/sel when holding, else it carries zeros.
  function automatic stage_t advance(input stage_t inc, input stage_t cur);
    stage_t nxt;
    nxt = inc;
    if (!inc.vld && HOLD_OUT) begin
      nxt.sel = cur.sel;
      nxt.dat = cur.dat;
    end
    return nxt;
  endfunction

  always_comb begin
    mux_dat = '0;
    sel_oor = 1'b1;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (sel == SEL_W'(i)) begin
        mux_dat = in[i];
        sel_oor = 1'b0;
      end
    end

    beat_in = '0;
    if (in_valid) begin
      beat_in.vld = 1'b1;
      beat_in.err = sel_oor;
      beat_in.sel = sel;
      beat_in.dat = mux_dat;
    end

    stg_d = stg_q;
    if (!stall) begin
      stg_d[0] = advance(beat_in, stg_q[0]);
      for (int k = 1; k < NSTG; k++) begin
        stg_d[k] = advance(stg_q[k-1], stg_q[k]);
      end
    end

    // A new out-of-range acceptance beats a simultaneous clear.
    err_sticky_d = err_sticky_q;
    if (in_valid && !stall && sel_oor) begin
      err_sticky_d = 1'b1;
    end else if (err_clr) begin
      err_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSTG; k++) begin
        stg_q[k] <= '0;
      end
      err_sticky_q <= 1'b0;
    end else begin
      for (int k = 0; k < NSTG; k++) begin
        stg_q[k] <= stg_d[k];
      end
      err_sticky_q <= err_sticky_d;
    end
  end

  assign out        = stg_q[NSTG-1].dat;
  assign out_valid  = stg_q[NSTG-1].vld;
  assign out_sel    = stg_q[NSTG-1].sel;
  assign sel_err    = stg_q[NSTG-1].vld & stg_q[NSTG-1].err;
  assign err_sticky = err_sticky_q;

endmodule

// File: doc/pipe_mux.md
Name: pipe_mux

Overview:
- Parametrised, pipelined successor to the datapath N-to-1 mux used in the processor's operand and writeback select paths.
- Selects one of N_INPUTS data words per cycle and carries a valid tag through LATENCY register stages.
- Supports stall (freeze) of the whole pipe.
- Flags out-of-range selects with a per-beat error and a sticky, clearable error bit.

Parameters:
- N_INPUTS, 2, number of data inputs; >=1.
- DWIDTH, 8, width of each data word.
- LATENCY, 1, register stages from input to output; >=1.
- SEL_W, (N_INPUTS>1 ? $clog2(N_INPUTS) : 1), select width; derived, not overridden.
- HOLD_OUT, 1, 1: out holds its last valid value on bubbles; 0: out is zero whenever out_valid=0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  current beat on in/sel is valid.
- in  input  DWIDTH x N_INPUTS (unpacked array [N_INPUTS])  data inputs.
- sel  input  SEL_W  index of the selected input.
- stall  input  1  freeze all stages; in_valid is ignored while high.
- out  output  DWIDTH  selected data, LATENCY cycles after acceptance.
- out_valid  output  1  out carries a valid beat.
- out_sel  output  SEL_W  sel value that produced out.
- sel_err  output  1  the current out beat had sel >= N_INPUTS; qualified by out_valid.
- err_sticky  output  1  latched on any accepted out-of-range beat.
- err_clr  input  1  synchronous clear of err_sticky.

Behaviour:
- Reset, asynchronous: all stage valids = 0, all stage data = 0. Outputs: out=0, out_valid=0, out_sel=0, sel_err=0, err_sticky=0.
- Acceptance: a beat is accepted on a rising edge with in_valid=1 and stall=0.
- Bubbles: if stall=0 and in_valid=0, a bubble (valid=0) enters stage 0.
- Stage 0 captures:
  - data = in[sel] if sel < N_INPUTS, else 0.
  - sel.
  - err = (sel >= N_INPUTS).
  - valid.
- Stage k+1 takes stage k each cycle stall=0. Outputs are driven directly from the last stage; no combinational path from inputs to outputs.
- Latency: exactly LATENCY non-stalled cycles. An in_valid beat accepted at edge t appears on out_valid at edge t+LATENCY when no stall occurs. Each stalled cycle adds one.
- Stall: when stall=1, every stage including the output holds its value; out_valid stays as it was. No beats are lost or duplicated across a stall of any length.
- HOLD_OUT=1: bubble stages keep their prior data and sel. out shows the last valid data while out_valid=0.
- HOLD_OUT=0: bubble stages load data=0, sel=0.
- sel_err is 0 whenever out_valid=0.
- err_sticky:
  - Set on the edge where an out-of-range beat is accepted at the input, not when it reaches the output.
  - err_clr clears it.
  - If err_clr and a new out-of-range acceptance occur on the same edge, set wins and err_sticky=1.
- N_INPUTS=1: sel is 1 bit; only sel=0 is in range; sel=1 produces an error beat.
- Non-power-of-two N_INPUTS: sel values N_INPUTS..2^SEL_W-1 are out of range.
- Reset mid-operation: all in-flight beats are discarded. out_valid falls immediately, asynchronously. The first beat after rst deasserts follows the normal latency.
- Throughput: one beat per non-stalled cycle; back-to-back acceptance is supported indefinitely.

Test Plan:
1. N_INPUTS=4, DWIDTH=8, LATENCY=2. in={0x11,0x22,0x33,0x44}; drive in_valid=1 with sel=2 at edge 0 and sel=0 at edge 1. Required: out=0x33, out_valid=1, out_sel=2 after edge 2; out=0x11, out_sel=0 after edge 3; out_valid=0 after edge 4.
2. Same configuration, beat sel=3 accepted at edge 0, stall=1 for edges 1–3, stall=0 afterwards. Required: out=0x44 with out_valid=1 first visible after edge 5. out_valid=1 lasts exactly one non-stalled cycle; no duplicate beat.
3. N_INPUTS=3, LATENCY=1, beat sel=3 accepted at edge 0. Required:
   - err_sticky=1 after edge 0.
   - After edge 1: out=0, sel_err=1, out_valid=1.
   - err_clr=1 at edge 2 gives err_sticky=0.
   - Repeat with err_clr=1 on the same edge as an accepted sel=3 beat: err_sticky=1.
4. HOLD_OUT=1, LATENCY=1. Beat sel=1 (0x22) is followed by three bubbles. Required: out stays 0x22 with out_valid=0. With HOLD_OUT=0 the same stimulus gives out=0 during the bubbles.
5. LATENCY=3, three back-to-back beats sel=0,1,2. Assert rst between edge 1 and edge 2 for 1 cycle. Required: out_valid=0 immediately while rst is high. No pre-reset beat ever appears at the output. A beat accepted 2 edges after deassertion appears 3 edges later.
6. N_INPUTS=1, LATENCY=1. Required: sel=0 passes in[0]; sel=1 gives out=0 with sel_err=1.
